// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master slice.
//   SPI_DATA_W      : transfer width in bits (fixed at 16)
//   SPI_HALF_PERIOD : default clk cycles per SCLK half-period
//   SPI_BIT_CNT_W   : width of the per-word bit counter (counts 0..16)
//   spi_state_t     : transfer FSM states
//   is_last_bit     : true when the bit counter points at the final bit
package spi_pkg;

    localparam int SPI_DATA_W      = 16;
    localparam int SPI_HALF_PERIOD = 4;
    localparam int SPI_BIT_CNT_W   = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } spi_state_t;

    function automatic logic is_last_bit(input logic [SPI_BIT_CNT_W-1:0] cnt);
        return (cnt == SPI_BIT_CNT_W'(SPI_DATA_W - 1));
    endfunction

endpackage

// File: rtl/spi_if.sv
// Bundle of the SPI master's request/data signals and the card-side pins.
//   EN, dataIN      : transfer request and word to send (controller -> master)
//   dataOUT, DONE   : received word and completion pulse (master -> controller)
//   MOSI, CS, SCLK  : serial pins driven by the master
//   MISO            : serial data returned by the card
// Modport master is the spi_master view; modport slave is the view of
// whatever surrounds it (controller logic plus card).
interface spi_if
    import spi_pkg::*;
();

    logic                  EN;
    logic [SPI_DATA_W-1:0] dataIN;
    logic                  MISO;
    logic [SPI_DATA_W-1:0] dataOUT;
    logic                  DONE;
    logic                  MOSI;
    logic                  CS;
    logic                  SCLK;

    modport master (
        input  EN, dataIN, MISO,
        output dataOUT, DONE, MOSI, CS, SCLK
    );

    modport slave (
        output EN, dataIN, MISO,
        input  dataOUT, DONE, MOSI, CS, SCLK
    );

endinterface

// File: rtl/spi_sclk_gen.sv
// SCLK half-period divider.
//   clk, reset   : system clock, asynchronous active-low reset
//   i_enable     : count while high (transfer in progress)
//   i_clear      : restart the divider with SCLK low (transfer start)
//   o_rise_tick  : strobe on the clk edge where SCLK goes high
//   o_fall_tick  : strobe on the clk edge where SCLK goes low
//   o_sclk       : registered SCLK level, idle low
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int HALF_PERIOD = SPI_HALF_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic i_enable,
    input  logic i_clear,
    output logic o_rise_tick,
    output logic o_fall_tick,
    output logic o_sclk
);

    localparam int              CNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF_PERIOD - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_sclk;
    logic             w_tick;

    // A tick marks the last clk of a half-period; the toggle lands on that edge.
    assign w_tick      = i_enable & (r_cnt == LAST);
    assign o_rise_tick = w_tick & ~r_sclk;
    assign o_fall_tick = w_tick &  r_sclk;
    assign o_sclk      = r_sclk;

    // Half-period counter and SCLK level register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (i_clear) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (w_tick) begin
            r_cnt  <= '0;
            r_sclk <= ~r_sclk;
        end else if (i_enable) begin
            r_cnt  <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt  <= r_cnt;
        end
    end

endmodule

// File: rtl/spi_master.sv
// 16-bit full-duplex SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
//   clk, reset : system clock, asynchronous active-low reset
//   bus        : spi_if.master (EN/dataIN in, dataOUT/DONE out, SPI pins)
// Parameters: HALF_PERIOD = clk cycles per SCLK half (>= 1), DATA_W = 16.
// CS, DONE and dataOUT are registered from the next state, so they change on
// the same edge the FSM enters FINISH: CS is low for exactly 32*HALF_PERIOD
// clk and, with EN held, high for exactly two clk (FINISH, IDLE) between words.
module spi_master
    import spi_pkg::*;
#(
    parameter int HALF_PERIOD = SPI_HALF_PERIOD,
    parameter int DATA_W      = SPI_DATA_W
) (
    input  logic     clk,
    input  logic     reset,
    spi_if.master    bus
);

    spi_state_t               r_state;
    spi_state_t               w_next_state;
    logic                     w_load;
    logic                     w_div_en;
    logic                     w_rise;
    logic                     w_fall;
    logic                     w_sclk;
    logic [DATA_W-1:0]        r_tx;
    logic [DATA_W-1:0]        r_rx;
    logic [DATA_W-1:0]        r_data_out;
    logic [SPI_BIT_CNT_W-1:0] r_bitcnt;
    logic                     r_mosi;
    logic                     r_cs;
    logic                     r_done;

    assign w_div_en = (r_state == SHIFT);

    spi_sclk_gen #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_sclk_gen (
        .clk         (clk),
        .reset       (reset),
        .i_enable    (w_div_en),
        .i_clear     (w_load),
        .o_rise_tick (w_rise),
        .o_fall_tick (w_fall),
        .o_sclk      (w_sclk)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and transfer-start strobe.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.EN) begin
                    w_load       = 1'b1;
                    w_next_state = SHIFT;
                end else begin
                    w_next_state = IDLE;
                end
            end
            SHIFT: begin
                if (w_fall && is_last_bit(r_bitcnt)) begin
                    w_next_state = FINISH;
                end else begin
                    w_next_state = SHIFT;
                end
            end
            FINISH: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Shift registers, bit counter and registered pin/handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx       <= '0;
            r_rx       <= '0;
            r_data_out <= '0;
            r_bitcnt   <= '0;
            r_mosi     <= 1'b0;
            r_cs       <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_cs   <= (w_next_state != SHIFT);
            r_done <= (w_next_state == FINISH);
            // The last MISO bit was taken half a period earlier, so r_rx is complete here.
            if ((r_state == SHIFT) && (w_next_state == FINISH)) begin
                r_data_out <= r_rx;
            end
            if (w_load) begin
                r_tx     <= bus.dataIN;
                r_mosi   <= bus.dataIN[DATA_W-1];
                r_rx     <= '0;
                r_bitcnt <= '0;
            end else if (w_rise) begin
                r_rx <= {r_rx[DATA_W-2:0], bus.MISO};
            end else if (w_fall) begin
                r_bitcnt <= r_bitcnt + SPI_BIT_CNT_W'(1);
                // After the final bit MOSI simply holds; it is don't-care once CS is high.
                if (!is_last_bit(r_bitcnt)) begin
                    r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
                    r_mosi <= r_tx[DATA_W-2];
                end
            end
        end
    end

    assign bus.MOSI    = r_mosi;
    assign bus.CS      = r_cs;
    assign bus.SCLK    = w_sclk;
    assign bus.DONE    = r_done;
    assign bus.dataOUT = r_data_out;

endmodule

// File: tb/tb_spi_master.sv
module tb_spi_master;
    import spi_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Two builds: index 0 has HALF_PERIOD=4, index 1 has HALF_PERIOD=1.
    spi_if bus0 ();
    spi_if bus1 ();

    spi_master #(.HALF_PERIOD(4), .DATA_W(16)) dut0 (.clk(clk), .reset(reset), .bus(bus0.master));
    spi_master #(.HALF_PERIOD(1), .DATA_W(16)) dut1 (.clk(clk), .reset(reset), .bus(bus1.master));

    logic [1:0]  en_r = 2'b00;
    logic [1:0]  miso_r = 2'b00;
    logic [15:0] din [2];
    logic [15:0] slave_word [2];
    int          tie_mode [2];   // 0: slave word, 1: MISO tied 0, 2: MISO tied 1

    assign bus0.EN = en_r[0];  assign bus0.dataIN = din[0];  assign bus0.MISO = miso_r[0];
    assign bus1.EN = en_r[1];  assign bus1.dataIN = din[1];  assign bus1.MISO = miso_r[1];

    wire [1:0]  cs_w   = {bus1.CS,   bus0.CS};
    wire [1:0]  sclk_w = {bus1.SCLK, bus0.SCLK};
    wire [1:0]  mosi_w = {bus1.MOSI, bus0.MOSI};
    wire [1:0]  done_w = {bus1.DONE, bus0.DONE};
    wire [15:0] dout_w [2];
    assign dout_w[0] = bus0.dataOUT;
    assign dout_w[1] = bus1.dataOUT;

    // Monitor / slave-model state (written only by the monitor process).
    logic [1:0]  prev_cs = 2'b11;
    logic [1:0]  prev_sclk = 2'b00;
    logic [15:0] sh [2];
    logic [15:0] mword [2];
    logic [15:0] last_out [2];
    logic [15:0] word_hist [2][16];
    int cs_low_tot [2];
    int pulses_tot [2];
    int done_tot [2];
    int words_tot [2];
    int starts_tot [2];
    int hi_run [2];
    int last_gap [2];

    int n_checks = 0;
    int n_fail = 0;

    // Pin monitor and SPI slave model, sampled on the falling clk edge.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!cs_w[d]) cs_low_tot[d] <= cs_low_tot[d] + 1;
            else          hi_run[d]     <= hi_run[d] + 1;
            if (prev_cs[d] && !cs_w[d]) begin
                starts_tot[d] <= starts_tot[d] + 1;
                last_gap[d]   <= hi_run[d];
                hi_run[d]     <= 0;
                sh[d]         <= slave_word[d] << 1;
                miso_r[d]     <= (tie_mode[d] == 0) ? slave_word[d][15] : (tie_mode[d] == 2);
            end else if (!prev_sclk[d] && sclk_w[d]) begin
                pulses_tot[d] <= pulses_tot[d] + 1;
                mword[d]      <= {mword[d][14:0], mosi_w[d]};
            end else if (prev_sclk[d] && !sclk_w[d] && !cs_w[d]) begin
                miso_r[d] <= (tie_mode[d] == 0) ? sh[d][15] : (tie_mode[d] == 2);
                sh[d]     <= sh[d] << 1;
            end
            if (!prev_cs[d] && cs_w[d]) begin
                words_tot[d] <= words_tot[d] + 1;
                word_hist[d][words_tot[d] % 16] <= mword[d];
            end
            if (done_w[d]) begin
                done_tot[d] <= done_tot[d] + 1;
                last_out[d] <= dout_w[d];
            end
        end
        prev_cs   <= cs_w;
        prev_sclk <= sclk_w;
    end

    typedef struct {
        logic [15:0] mosi;
        logic [15:0] out;
        int          pulses;
        int          cs_low;
        int          dones;
    } exp_t;

    typedef struct {
        logic [15:0] tx;
        logic [15:0] sw;
        int          mode;
        logic [15:0] exp_mosi;
        logic [15:0] exp_out;
    } vec_t;

    // Reference: a mode-0 word transfer sends tx, returns what MISO carried,
    // with 16 SCLK pulses of 2*hp clk and CS low for 32*hp clk.
    function automatic exp_t model(input int hp, input logic [15:0] tx,
                                   input logic [15:0] sw, input int mode);
        exp_t e;
        e.mosi   = tx;
        e.out    = (mode == 1) ? 16'h0000 : ((mode == 2) ? 16'hFFFF : sw);
        e.pulses = 16;
        e.cs_low = 2 * 16 * hp;
        e.dones  = 1;
        return e;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic xfer(input int d, input logic [15:0] tx, input logic [15:0] sw,
                        input int mode, input string nm);
        exp_t e;
        int hp, p0, c0, d0, w0;
        hp = (d == 0) ? 4 : 1;
        e  = model(hp, tx, sw, mode);
        slave_word[d] = sw;
        tie_mode[d]   = mode;
        tick();
        p0 = pulses_tot[d]; c0 = cs_low_tot[d]; d0 = done_tot[d]; w0 = words_tot[d];
        din[d]  = tx;
        en_r[d] = 1'b1;
        tick();
        en_r[d] = 1'b0;
        for (int i = 0; i < 40 * hp + 20 && words_tot[d] == w0; i++) tick();
        check({nm, "_done_seen"}, 32'(words_tot[d] - w0), 32'd1);
        check({nm, "_mosi"},      32'(word_hist[d][w0 % 16]), 32'(e.mosi));
        check({nm, "_dataOUT"},   32'(last_out[d]), 32'(e.out));
        check({nm, "_pulses"},    32'(pulses_tot[d] - p0), 32'(e.pulses));
        check({nm, "_cs_low"},    32'(cs_low_tot[d] - c0), 32'(e.cs_low));
        tick(); tick(); tick();
        check({nm, "_done_once"}, 32'(done_tot[d] - d0), 32'(e.dones));
    endtask

    initial begin
        vec_t vt [5];
        int p0, d0, s0, w0;
        din[0] = 16'h0000; din[1] = 16'h0000;
        slave_word[0] = 16'h0000; slave_word[1] = 16'h0000;
        tie_mode[0] = 0; tie_mode[1] = 0;

        vt[0] = '{16'hAB52, 16'h9D5B, 0, 16'hAB52, 16'h9D5B};
        vt[1] = '{16'h1234, 16'h0000, 2, 16'h1234, 16'hFFFF};
        vt[2] = '{16'hFFFF, 16'hFFFF, 1, 16'hFFFF, 16'h0000};
        vt[3] = '{16'h0000, 16'hA5A5, 0, 16'h0000, 16'hA5A5};
        vt[4] = '{16'h8001, 16'h7FFE, 0, 16'h8001, 16'h7FFE};

        // Reset held with EN high: everything stays quiet.
        #1 reset = 1'b0;
        en_r = 2'b11;
        din[0] = 16'hFFFF; din[1] = 16'hFFFF;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("rst_cs",      32'(cs_w), 32'd3);
            check("rst_sclk",    32'(sclk_w), 32'd0);
            check("rst_done",    32'(done_w), 32'd0);
            check("rst_dataOUT", 32'({dout_w[1], dout_w[0]}), 32'd0);
        end
        check("rst_no_pulses", 32'(pulses_tot[0] + pulses_tot[1]), 32'd0);
        en_r = 2'b00;
        tick();
        reset = 1'b1;
        tick();

        // Table-driven single transfers on the HALF_PERIOD=4 build.
        for (int k = 0; k < 5; k++) begin
            exp_t e;
            e = model(4, vt[k].tx, vt[k].sw, vt[k].mode);
            check($sformatf("tbl%0d_model_mosi", k), 32'(e.mosi), 32'(vt[k].exp_mosi));
            check($sformatf("tbl%0d_model_out", k),  32'(e.out),  32'(vt[k].exp_out));
            xfer(0, vt[k].tx, vt[k].sw, vt[k].mode, $sformatf("tbl%0d", k));
        end

        // HALF_PERIOD=1 build: single transfer.
        xfer(1, 16'hAB52, 16'h9D5B, 0, "hp1_single");

        // Randomized transfers on both builds.
        for (int k = 0; k < 6; k++)
            xfer(0, 16'($urandom), 16'($urandom), 0, $sformatf("rnd_hp4_%0d", k));
        for (int k = 0; k < 3; k++)
            xfer(1, 16'($urandom), 16'($urandom), 0, $sformatf("rnd_hp1_%0d", k));

        // Back-to-back with EN held; dataIN changes during word 1.
        slave_word[0] = 16'h0F0F; tie_mode[0] = 0;
        tick();
        s0 = starts_tot[0]; w0 = words_tot[0]; d0 = done_tot[0]; p0 = pulses_tot[0];
        din[0] = 16'hAB52;
        en_r[0] = 1'b1;
        for (int i = 0; i < 100 && (pulses_tot[0] - p0) < 4; i++) tick();
        din[0] = 16'h1234;
        for (int i = 0; i < 400 && (starts_tot[0] - s0) < 2; i++) tick();
        en_r[0] = 1'b0;
        check("b2b_second_start", 32'(starts_tot[0] - s0), 32'd2);
        check("b2b_cs_gap", 32'(last_gap[0]), 32'd2);
        for (int i = 0; i < 200 && (words_tot[0] - w0) < 2; i++) tick();
        tick(); tick(); tick(); tick();
        check("b2b_word1", 32'(word_hist[0][w0 % 16]), 32'h0000AB52);
        check("b2b_word2", 32'(word_hist[0][(w0 + 1) % 16]), 32'h00001234);
        check("b2b_dones", 32'(done_tot[0] - d0), 32'd2);
        check("b2b_no_third", 32'(starts_tot[0] - s0), 32'd2);
        check("b2b_dataOUT", 32'(last_out[0]), 32'h00000F0F);

        // Reset after the 8th SCLK rise aborts the word immediately.
        slave_word[0] = 16'h9D5B;
        tick();
        p0 = pulses_tot[0]; d0 = done_tot[0];
        din[0] = 16'hAB52;
        en_r[0] = 1'b1;
        tick();
        en_r[0] = 1'b0;
        for (int i = 0; i < 100 && (pulses_tot[0] - p0) < 8; i++) tick();
        check("midrst_reached_8", 32'(pulses_tot[0] - p0), 32'd8);
        reset = 1'b0;
        #1;
        check("midrst_cs_async",   32'(bus0.CS), 32'd1);
        check("midrst_sclk_async", 32'(bus0.SCLK), 32'd0);
        for (int i = 0; i < 3; i++) tick();
        check("midrst_dataOUT", 32'(dout_w[0]), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("midrst_no_done", 32'(done_tot[0] - d0), 32'd0);
        xfer(0, 16'h5A3C, 16'hC3E1, 0, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
